neg16_serial: RTL and testbench

Bit-serial 16-bit complement unit. It accepts one 16-bit word over a valid/ready handshake and returns either its bitwise NOT or its two's-complement negation (NOT + 1), processing one bit per clock, LSB first. It sits beside the combinational 16-bit gate library as the low-area sequential counterpart. It is used where a Hack-style datapath trades 16 cycles of latency for a single-bit inverter/half-adder slice.

---
 rtl/neg16_serial.sv | 131 +++++++++++++
 tb/tb_neg16_serial.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neg16_serial.sv
// Bit-serial 16-bit complement unit: bitwise NOT or two's-complement negate, one bit per clock, LSB first.
// Optional overflow flag port ovf_o is built only when NEG16_SERIAL_OVF_EN is defined.
module neg16_serial (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_i,
    input  logic        mode_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_o,
    output logic        busy_o
`ifdef NEG16_SERIAL_OVF_EN
    ,
    output logic        ovf_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] res_q, res_d;
    logic [15:0] out_q, out_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        c_q, c_d;
    logic        out_valid_q, out_valid_d;
`ifdef NEG16_SERIAL_OVF_EN
    logic        mode_q, mode_d;
    logic        ovf_q, ovf_d;
`endif

    // One inverter + half-adder slice; carry starts at mode so NOT needs no separate path.
    logic        bit_n;
    logic        sum;
    logic [15:0] res_shift;

    assign bit_n     = ~sh_q[0];
    assign sum       = bit_n ^ c_q;
    assign res_shift = {sum, res_q[15:1]};

    assign in_ready_o  = (state_q == IDLE) & ~reset_i;
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;
`ifdef NEG16_SERIAL_OVF_EN
    assign ovf_o       = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        res_d   = res_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
`ifdef NEG16_SERIAL_OVF_EN
        mode_d  = mode_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    sh_d    = in_i;
                    c_d     = mode_i;
                    cnt_d   = 4'd0;
`ifdef NEG16_SERIAL_OVF_EN
                    mode_d  = mode_i;
                    ovf_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                c_d   = bit_n & c_q;
                res_d = res_shift;
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    out_d   = res_shift;
                    state_d = DONE;
`ifdef NEG16_SERIAL_OVF_EN
                    // Carry into bit 15 with in[15]=1 only happens for 0x8000 in negate mode.
                    ovf_d   = mode_q & c_q & sh_q[0];
`endif
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            sh_q        <= 16'h0000;
            res_q       <= 16'h0000;
            out_q       <= 16'h0000;
            cnt_q       <= 4'd0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef NEG16_SERIAL_OVF_EN
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            res_q       <= res_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
`ifdef NEG16_SERIAL_OVF_EN
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_neg16_serial.sv
// Directed self-checking bench for neg16_serial; ovf checks are built when NEG16_SERIAL_OVF_EN is defined.
module tb_neg16_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
`ifdef NEG16_SERIAL_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neg16_serial dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_i        (in_data),
        .mode_i      (mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out_data),
        .busy_o      (busy)
`ifdef NEG16_SERIAL_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one word for exactly one accept edge.
    task automatic send(input logic [15:0] w, input logic m);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = w;
        mode     = m;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        mode      = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef NEG16_SERIAL_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_not_latency();
        int n;
        out_ready = 1'b1;
        send(16'h00FF, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL not_busy: got %b want 1", busy); end
        wait_done(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL not_latency: got %0d cycles want 16", n); end
        checks++; if (out_data !== 16'hFF00) begin errors++; $display("FAIL not_00ff: got %h want ff00", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL not_ready_in_done: got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL not_roundtrip_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL not_valid_drop: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'hFF00) begin errors++; $display("FAIL not_out_hold: got %h want ff00", out_data); end
    endtask

    task automatic test_negate();
        logic [15:0] vin [4];
        logic [15:0] vexp [4];
        int n;
        vin[0] = 16'h0001; vexp[0] = 16'hFFFF;
        vin[1] = 16'h0000; vexp[1] = 16'h0000;
        vin[2] = 16'h7FFF; vexp[2] = 16'h8001;
        vin[3] = 16'hFFFF; vexp[3] = 16'h0001;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vin[i], 1'b1);
            wait_done(n);
            checks++;
            if (out_valid !== 1'b1 || out_data !== vexp[i]) begin
                errors++;
                $display("FAIL negate_%h: got valid=%b out=%h want valid=1 out=%h", vin[i], out_valid, out_data, vexp[i]);
            end
`ifdef NEG16_SERIAL_OVF_EN
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL negate_ovf_%h: got %b want 0", vin[i], ovf); end
`endif
            step();
        end
    endtask

`ifdef NEG16_SERIAL_OVF_EN
    task automatic test_ovf();
        int n;
        out_ready = 1'b1;
        send(16'h8000, 1'b1);
        wait_done(n);
        checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL ovf_neg_out: got %h want 8000", out_data); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg_flag: got %b want 1", ovf); end
        step();
        send(16'h8000, 1'b0);
        wait_done(n);
        checks++; if (out_data !== 16'h7FFF) begin errors++; $display("FAIL ovf_not_out: got %h want 7fff", out_data); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_not_flag: got %b want 0", ovf); end
        step();
    endtask
`endif

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        send(16'h0F0F, 1'b0);
        wait_done(n);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hF0F0) begin errors++; $display("FAIL bp_first: got valid=%b out=%h want 1/f0f0", out_valid, out_data); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hBEEF;
            mode     = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hF0F0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b out=%h ready=%b want 1/f0f0/0", i, out_valid, out_data, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || out_data !== 16'hF0F0) begin errors++; $display("FAIL bp_release: got busy=%b out=%h want 0/f0f0", busy, out_data); end
        send(16'h1234, 1'b0);
        wait_done(n);
        checks++; if (out_data !== 16'hEDCB) begin errors++; $display("FAIL b2b_1234: got %h want edcb", out_data); end
        send(16'hA5A5, 1'b0);
        wait_done(n);
        checks++; if (out_data !== 16'h5A5A) begin errors++; $display("FAIL b2b_a5a5: got %h want 5a5a", out_data); end
        step();
    endtask

    task automatic test_isolation();
        int n;
        out_ready = 1'b1;
        send(16'h0003, 1'b1);
        n = 0;
        while (!out_valid && n < 40) begin
            in_data = 16'($urandom);
            mode    = ~mode;
            step();
            n++;
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hFFFD) begin errors++; $display("FAIL isolation: got valid=%b out=%h want 1/fffd", out_valid, out_data); end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b1;
        send(16'h1111, 1'b0);
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_out: got %h want 0000", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
        send(16'h0002, 1'b1);
        wait_done(n);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hFFFE) begin errors++; $display("FAIL rst_mid_next: got valid=%b out=%h want 1/fffe", out_valid, out_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_not_latency();
        test_negate();
`ifdef NEG16_SERIAL_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_isolation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
